// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit state.
package uart_pkg;

    localparam int DEFAULT_CYCLES_PER_BIT = 21812;
    localparam int DATA_BITS_PER_FRAME    = 8;

    // Frame states; encoding is fixed at 3 bits so both builds share one width.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START_BIT = 3'd1,
        DATA_BITS = 3'd2,
        STOP_BIT  = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        PARITY_BIT = 3'd4
`endif
    } TxState;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: free-running counter that pulses o_tick on the last
// cycle of each bit period and restarts from zero whenever i_clear is high.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int CNT_W          = 24
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CYCLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = !i_clear && (cnt_q == LAST_COUNT);

    // Next count: wrap at the bit boundary, hold at zero while cleared.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clear || (cnt_q == LAST_COUNT)) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge i_reset_n) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (!i_reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a one-entry holding register for back-to-back
// frames. Byte bit i_data[0] goes on the wire first; o_tx is a flop.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// before the stop bit (frame becomes 11 bit periods).
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic [0:7] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS_PER_FRAME - 1);

    TxState     state_q,      state_d;
    logic [0:7] hold_data_q,  hold_data_d;
    logic       hold_valid_q, hold_valid_d;
    logic [0:7] shift_q,      shift_d;
    logic [2:0] bit_idx_q,    bit_idx_d;
    logic       tx_q,         tx_d;

    logic bit_tick;
    logic timer_clear;
    logic accept;

    // The timer idles at zero so the start bit always gets a full period.
    assign timer_clear = (state_q == IDLE);
    assign accept      = i_valid && !hold_valid_q;

    assign o_ready = !hold_valid_q;
    assign o_tx    = tx_q;
    assign o_busy  = (state_q != IDLE);

    uart_bit_timer #(
        .CYCLES_PER_BIT(CYCLES_PER_BIT),
        .CNT_W         (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .i_clear  (timer_clear),
        .o_tick   (bit_tick)
    );

    // Next-state logic: byte acceptance, frame sequencing and line level.
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;

        // Acceptance needs an empty holder and launch needs a full one,
        // so the two never collide on hold_valid_d.
        if (accept) begin
            hold_data_d  = i_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_valid_q) begin
                    shift_d      = hold_data_q;
                    hold_valid_d = 1'b0;
                    state_d      = START_BIT;
                end
            end
            START_BIT: begin
                if (bit_tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (bit_tick) begin
                    if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY_BIT;
`else
                        state_d = STOP_BIT;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: begin
                if (bit_tick) begin
                    state_d = STOP_BIT;
                end
            end
`endif
            STOP_BIT: begin
                if (bit_tick) begin
                    if (hold_valid_q) begin
                        // Queued byte launches straight into its start bit.
                        shift_d      = hold_data_q;
                        hold_valid_d = 1'b0;
                        state_d      = START_BIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the registered state, one cycle behind it.
        case (state_q)
            START_BIT: tx_d = 1'b0;
            DATA_BITS: tx_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY_BIT: tx_d = ^shift_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // Frame state machine and holding register; reset aborts any frame.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= IDLE;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            shift_q      <= shift_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter (default 8N1 build, 4 cycles/bit).
// A frame-level model predicts the line, ready and busy on every cycle;
// directed steps add literal waveform checks and a wire decoder.
module tb_uart_transmitter;

    localparam int CPB     = 4;
    localparam int FRAME_C = 10 * CPB;
    localparam int LOG_N   = 8192;

    logic       clk       = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_valid   = 1'b0;
    logic [0:7] i_data    = '0;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CYCLES_PER_BIT(CPB),
        .CNT_W         (24)
    ) dut (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_tx     (o_tx),
        .o_busy   (o_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic tx_log   [LOG_N];
    logic rdy_log  [LOG_N];
    logic busy_log [LOG_N];

    // Reference model: list of frames (wire start cycle, byte) plus holder window.
    int         f_start[$];
    logic [0:7] f_data[$];
    logic [0:7] acc_q[$];
    logic [0:7] dec_q[$];
    int         hold_acc   = -1;
    int         hold_rel   = -1;
    int         last_start = -100000;
    logic       m_ready    = 1'b1;
    logic       last_acc   = 1'b0;

    task automatic model_clear();
        f_start.delete();
        f_data.delete();
        hold_acc   = -1;
        hold_rel   = -1;
        last_start = -100000;
        m_ready    = 1'b1;
    endtask

    // Byte accepted at edge c: its start bit hits the wire two edges later,
    // or right after the previous frame if that is still running.
    task automatic model_accept(input int c, input logic [0:7] d);
        int s;
        s = (c + 2 > last_start + FRAME_C) ? c + 2 : last_start + FRAME_C;
        f_start.push_back(s);
        f_data.push_back(d);
        last_start = s;
        hold_acc   = c;
        hold_rel   = s - 1;
    endtask

    function automatic logic model_ready_after(input int c);
        return !(c >= hold_acc && c < hold_rel);
    endfunction

    function automatic logic exp_tx(input int c);
        foreach (f_start[i]) begin
            if (c >= f_start[i] && c < f_start[i] + FRAME_C) begin
                int k;
                k = (c - f_start[i]) / CPB;
                if (k == 0) return 1'b0;
                if (k <= 8) return f_data[i][k-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (f_start[i]) begin
            if (c >= f_start[i] - 1 && c < f_start[i] - 1 + FRAME_C) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model on the edge, sample #1 later.
    task automatic step(input logic v, input logic [0:7] d);
        logic acc;
        i_valid = v;
        i_data  = d;
        acc     = v && m_ready;
        @(posedge clk);
        cyc++;
        if (acc) begin
            model_accept(cyc, d);
            acc_q.push_back(d);
        end
        last_acc = acc;
        #1;
        m_ready = model_ready_after(cyc);
        check("tx", o_tx, exp_tx(cyc));
        check("ready", o_ready, m_ready);
        check("busy", o_busy, exp_busy(cyc));
        tx_log[cyc]   = o_tx;
        rdy_log[cyc]  = o_ready;
        busy_log[cyc] = o_busy;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    // Independent wire decoder: find start bits and sample mid-bit.
    task automatic decode(input int from, input int to);
        int c;
        logic [0:7] b;
        dec_q.delete();
        c = from;
        while (c <= to - FRAME_C) begin
            if (tx_log[c] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_log[c + CPB * (k + 1) + CPB / 2];
                dec_q.push_back(b);
                c += FRAME_C;
            end else begin
                c++;
            end
        end
    endtask

    task automatic compare_decoded(input string tag);
        check({tag, "_count"}, dec_q.size(), acc_q.size());
        for (int i = 0; i < dec_q.size() && i < acc_q.size(); i++) begin
            check({tag, "_byte"}, dec_q[i], acc_q[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "bench timed out");
    end

    initial begin
        int n, a, b, s, s1, w0, hi, guard, cnt;
        logic [0:9]  got10;
        logic [0:19] got20;

        // Reset state, then a long idle stretch.
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", o_tx, 1'b1);
        check("rst_ready", o_ready, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        i_reset_n = 1'b1;
        model_clear();
        idle(100);
        hi = 0;
        for (int c = 1; c <= 100; c++) hi += int'(tx_log[c]);
        check("idle_high", hi, 100);

        // Single byte: literal waveform, latency and busy length.
        step(1'b1, 8'b10100101);
        check("sb_acc", last_acc, 1'b1);
        n = cyc;
        idle(48);
        check("sb_lat_hi", tx_log[n + 1], 1'b1);
        check("sb_lat_lo", tx_log[n + 2], 1'b0);
        for (int k = 0; k < 10; k++) got10[k] = tx_log[n + 2 + CPB * k + CPB / 2];
        check("sb_wire", got10, 10'b0101001011);
        cnt = 0;
        for (int c = n; c <= n + 48; c++) cnt += int'(busy_log[c]);
        check("sb_busy_len", cnt, 40);

        // Back-to-back: 0x00 then 0xFF queued during the first frame.
        step(1'b1, 8'h00);
        a  = cyc;
        s1 = a + 2;
        step(1'b1, 8'hFF);
        guard = 1;
        while (!last_acc && guard < 100) begin
            step(1'b1, 8'hFF);
            guard++;
        end
        check("b2b_acc", last_acc, 1'b1);
        b = cyc;
        idle(90);
        for (int k = 0; k < 20; k++) got20[k] = tx_log[s1 + CPB * k + CPB / 2];
        check("b2b_wire", got20, 20'b0000000001_0111111111);
        check("b2b_gap", tx_log[s1 + FRAME_C], 1'b0);
        check("b2b_rdy_acc", rdy_log[b], 1'b0);
        check("b2b_rdy_lo", rdy_log[s1 + FRAME_C - 2], 1'b0);
        check("b2b_rdy_hi", rdy_log[s1 + FRAME_C - 1], 1'b1);

        // Backpressure: valid held high with changing data.
        acc_q.delete();
        w0 = cyc + 1;
        repeat (120) step(1'b1, 8'($urandom));
        idle(90);
        check("bp_some", acc_q.size() >= 2, 1'b1);
        decode(w0, cyc);
        compare_decoded("bp");

        // Random valid pattern and data.
        acc_q.delete();
        w0 = cyc + 1;
        repeat (300) step($urandom_range(0, 3) == 0, 8'($urandom));
        idle(90);
        decode(w0, cyc);
        compare_decoded("rnd");

        // Reset during data bit 3 (a low bit) aborts the frame.
        step(1'b1, 8'b11101111);
        s = cyc + 2;
        while (cyc < s + 4 * CPB + 1) step(1'b0, 8'h00);
        check("mid_pre_tx", o_tx, 1'b0);
        #2;
        i_reset_n = 1'b0;
        #1;
        check("mid_rst_tx", o_tx, 1'b1);
        check("mid_rst_ready", o_ready, 1'b1);
        check("mid_rst_busy", o_busy, 1'b0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        i_reset_n = 1'b1;
        model_clear();
        step(1'b1, 8'h3C);
        check("post_acc", last_acc, 1'b1);
        n = cyc;
        idle(48);
        for (int k = 0; k < 10; k++) got10[k] = tx_log[n + 2 + CPB * k + CPB / 2];
        check("post_wire", got10, 10'b0001111001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
